// File: rtl/dlfloat_result_serializer.sv
// Buffers 16-bit DLFloat16 MAC results and emits each one as two bytes on an 8-bit port.
// Latency: a word pushed into an empty idle block shows its first byte one edge later (handshake possible at the 2nd edge).
// Backpressure: byte_ready low stalls byte_out/byte_last; a full FIFO drops res_ready and drops offered words (sticky overflow).
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   res_valid/res_data       16-bit result word input; res_ready = FIFO not full
//   byte_out/byte_valid      byte stream output; byte_ready from downstream
//   byte_last                marks the second byte of each word
//   level                    FIFO occupancy (the word in the output shadow is not counted)
//   overflow                 sticky flag: a word was offered while full and was dropped
module dlfloat_result_serializer #(
  parameter int unsigned DEPTH     = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         res_valid,
  input  logic [15:0]                  res_data,
  output logic                         res_ready,
  output logic [7:0]                   byte_out,
  output logic                         byte_valid,
  input  logic                         byte_ready,
  output logic                         byte_last,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND1 = 2'd1,
    SEND2 = 2'd2
  } state_t;

  // Byte ordering within a word.
  function automatic logic [7:0] first_byte(input logic [15:0] w);
    return LSB_FIRST ? w[7:0] : w[15:8];
  endfunction

  function automatic logic [7:0] second_byte(input logic [15:0] w);
    return LSB_FIRST ? w[15:8] : w[7:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [15:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
  logic [LVL_W-1:0] level_q,      level_d;
  logic             overflow_q,   overflow_d;
  state_t           state_q,      state_d;
  logic [15:0]      shadow_q,     shadow_d;
  logic [7:0]       byte_out_q,   byte_out_d;
  logic             byte_valid_q, byte_valid_d;
  logic             byte_last_q,  byte_last_d;

  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        xfer;
  logic [15:0] head;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  assign fifo_full  = (level_q == LVL_FULL);
  assign fifo_empty = (level_q == '0);
  // Acceptance depends on the current fill only: a pop in the same cycle does
  // not open a slot for a simultaneous push.
  assign push       = res_valid && !fifo_full;
  assign head       = mem_q[rd_ptr_q];
  assign xfer       = byte_valid_q && byte_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (res_valid && fifo_full) begin
      overflow_d = 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Push is blocked when full and pop when empty, so level stays in [0, DEPTH].
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output FSM. Outputs are registered: the byte for the next state is computed
  // here and loaded together with the state transition.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = byte_valid_q;
    byte_last_d  = byte_last_q;
    pop          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          shadow_d     = head;
          byte_out_d   = first_byte(head);
          byte_valid_d = 1'b1;
          byte_last_d  = 1'b0;
          state_d      = SEND1;
        end
      end

      SEND1: begin
        if (xfer) begin
          byte_out_d  = second_byte(shadow_q);
          byte_last_d = 1'b1;
          state_d     = SEND2;
        end
      end

      SEND2: begin
        if (xfer) begin
          if (!fifo_empty) begin
            // Chain straight into the next word without an idle cycle.
            pop          = 1'b1;
            shadow_d     = head;
            byte_out_d   = first_byte(head);
            byte_valid_d = 1'b1;
            byte_last_d  = 1'b0;
            state_d      = SEND1;
          end else begin
            byte_out_d   = 8'h00;
            byte_valid_d = 1'b0;
            byte_last_d  = 1'b0;
            state_d      = IDLE;
          end
        end
      end

      default: begin
        byte_out_d   = 8'h00;
        byte_valid_d = 1'b0;
        byte_last_d  = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      state_q      <= IDLE;
      shadow_q     <= 16'h0000;
      byte_out_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      byte_last_q  <= byte_last_d;
    end
  end

  // Storage needs no reset: the pointers guarantee an entry is written before
  // it is ever read, so stale contents cannot leak out after a reset.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= res_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign res_ready  = !fifo_full;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign byte_last  = byte_last_q;
  assign level      = level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_dlfloat_result_serializer.sv
// Directed bench for dlfloat_result_serializer (DEPTH=4, LSB_FIRST=1).
// Inputs change and outputs are sampled on the falling edge of clk.
// Each step() advances exactly one rising edge.
module tb_dlfloat_result_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        byte_last;
  logic [2:0]  level;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  logic [15:0] words [5];

  always #5 clk = ~clk;

  dlfloat_result_serializer #(
    .DEPTH     (4),
    .LSB_FIRST (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_last  (byte_last),
    .level      (level),
    .overflow   (overflow)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] b, input logic last);
    chk({tag, ".vld"},  {15'h0, byte_valid}, 16'h0001);
    chk({tag, ".byte"}, {8'h0, byte_out},    {8'h0, b});
    chk({tag, ".last"}, {15'h0, byte_last},  {15'h0, last});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".vld"},   {15'h0, byte_valid}, 16'h0000);
    chk({tag, ".level"}, {13'h0, level},      16'h0000);
  endtask

  initial begin
    rst        = 1'b1;
    res_valid  = 1'b0;
    res_data   = 16'h0000;
    byte_ready = 1'b1;
    words[0] = 16'h0102;
    words[1] = 16'h0304;
    words[2] = 16'h0506;
    words[3] = 16'h0708;
    words[4] = 16'h090A;
    step();
    step();
    rst = 1'b0;

    // 1. Idle after reset
    for (int i = 0; i < 3; i++) begin
      chk_idle("t1.idle");
      chk("t1.rdy",  {15'h0, res_ready}, 16'h0001);
      chk("t1.ovf",  {15'h0, overflow},  16'h0000);
      chk("t1.byte", {8'h0, byte_out},   16'h0000);
      chk("t1.last", {15'h0, byte_last}, 16'h0000);
      step();
    end

    // 2. Single word, latency and byte order
    res_valid = 1'b1;
    res_data  = 16'h3C00;
    step();
    res_valid = 1'b0;
    chk("t2.vld_early", {15'h0, byte_valid}, 16'h0000);
    chk("t2.level1",    {13'h0, level},      16'h0001);
    step();
    chk_byte("t2.b0", 8'h00, 1'b0);
    chk("t2.level0", {13'h0, level}, 16'h0000);
    step();
    chk_byte("t2.b1", 8'h3C, 1'b1);
    step();
    chk_idle("t2.end");
    chk("t2.byte_idle", {8'h0, byte_out}, 16'h0000);

    // 3. Back-to-back words, no bubble
    res_valid = 1'b1;
    res_data  = 16'hA1B2;
    step();
    res_data  = 16'hC3D4;
    step();
    res_valid = 1'b0;
    chk_byte("t3.b0", 8'hB2, 1'b0);
    step();
    chk_byte("t3.b1", 8'hA1, 1'b1);
    step();
    chk_byte("t3.b2", 8'hD4, 1'b0);
    step();
    chk_byte("t3.b3", 8'hC3, 1'b1);
    step();
    chk_idle("t3.end");

    // 4. Fill under backpressure, overflow, full rule, in-order drain
    byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      res_valid = 1'b1;
      res_data  = words[i];
      step();
    end
    chk("t4.level_full", {13'h0, level},      16'h0004);
    chk("t4.rdy_full",   {15'h0, res_ready},  16'h0000);
    chk("t4.ovf_pre",    {15'h0, overflow},   16'h0000);
    res_data = 16'h0B0C;
    step();
    res_valid = 1'b0;
    chk("t4.ovf",        {15'h0, overflow},   16'h0001);
    chk("t4.level_keep", {13'h0, level},      16'h0004);
    chk_byte("t4.stall", 8'h02, 1'b0);
    byte_ready = 1'b1;
    step();
    chk_byte("t4.w0hi", 8'h01, 1'b1);
    // Offer a word while full in the same cycle a pop happens: must be refused.
    res_valid = 1'b1;
    res_data  = 16'hDEAD;
    step();
    res_valid = 1'b0;
    chk("t4.full_rule", {13'h0, level}, 16'h0003);
    for (int i = 1; i < 5; i++) begin
      chk_byte("t4.lo", words[i][7:0], 1'b0);
      step();
      chk_byte("t4.hi", words[i][15:8], 1'b1);
      step();
    end
    chk_idle("t4.end");
    chk("t4.rdy_back", {15'h0, res_ready}, 16'h0001);
    chk("t4.ovf_sticky", {15'h0, overflow}, 16'h0001);

    // 5. Long stall in SEND2
    res_valid = 1'b1;
    res_data  = 16'h5566;
    step();
    res_data  = 16'h7788;
    step();
    res_valid = 1'b0;
    chk_byte("t5.b0", 8'h66, 1'b0);
    step();
    byte_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk_byte("t5.hold", 8'h55, 1'b1);
      step();
    end
    byte_ready = 1'b1;
    chk_byte("t5.release", 8'h55, 1'b1);
    step();
    chk_byte("t5.next_lo", 8'h88, 1'b0);
    step();
    chk_byte("t5.next_hi", 8'h77, 1'b1);
    step();
    chk_idle("t5.end");

    // 6. Reset during SEND2 with three words queued
    byte_ready = 1'b0;
    res_valid  = 1'b1;
    res_data   = 16'hE1E2;
    step();
    res_data   = 16'hE3E4;
    step();
    res_data   = 16'hE5E6;
    step();
    res_data   = 16'hE7E8;
    step();
    res_valid  = 1'b0;
    byte_ready = 1'b1;
    step();
    byte_ready = 1'b0;
    chk_byte("t6.send2", 8'hE1, 1'b1);
    chk("t6.level3",   {13'h0, level},    16'h0003);
    chk("t6.ovf_pre",  {15'h0, overflow}, 16'h0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("t6.rst");
    chk("t6.ovf_clr", {15'h0, overflow},  16'h0000);
    chk("t6.byte",    {8'h0, byte_out},   16'h0000);
    chk("t6.last",    {15'h0, byte_last}, 16'h0000);
    chk("t6.rdy",     {15'h0, res_ready}, 16'h0001);
    byte_ready = 1'b1;
    res_valid  = 1'b1;
    res_data   = 16'h4321;
    step();
    res_valid  = 1'b0;
    step();
    chk_byte("t6.new_lo", 8'h21, 1'b0);
    step();
    chk_byte("t6.new_hi", 8'h43, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("t6.quiet");
    end

    // Zero word is sent, not suppressed
    res_valid = 1'b1;
    res_data  = 16'h0000;
    step();
    res_valid = 1'b0;
    step();
    chk_byte("zero.lo", 8'h00, 1'b0);
    step();
    chk_byte("zero.hi", 8'h00, 1'b1);
    step();
    chk_idle("zero.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
